// File: rtl/matrix_data_fetcher.sv
// Fetches DIM rows of A plus vector B from word-addressed memory and streams the unpacked
// elements into the multiplier FIFOs. Define FETCH_TIMEOUT_EN to enable the read watchdog.
module matrix_data_fetcher #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned DIM        = 8,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned WORD_WIDTH = DATA_WIDTH * DIM
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_read,
    input  logic                  mem_waitrequest,
    input  logic [WORD_WIDTH-1:0] mem_readdata,
    input  logic                  mem_readdatavalid,
    output logic [DATA_WIDTH-1:0] fifo_data,
    output logic [3:0]            fifo_sel,
    output logic                  fifo_wren,
    output logic                  fetch_done,
    output logic                  busy,
    output logic                  error
);

    localparam int unsigned RW = $clog2(DIM + 1);
    localparam int unsigned EW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [2:0] {IDLE, REQ, WAIT, UNPACK, DONE} state_t;

    state_t                  state;
    logic [RW-1:0]           row;
    logic [RW-1:0]           row_next;
    logic [EW-1:0]           elem;
    logic [WORD_WIDTH-1:0]   word;
    logic [ADDR_WIDTH-1:0]   base;
`ifdef FETCH_TIMEOUT_EN
    logic [7:0]              wdog;
`endif

    assign row_next = row + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            elem        <= '0;
            word        <= '0;
            base        <= '0;
            mem_address <= '0;
            mem_read    <= 1'b0;
            fifo_data   <= '0;
            fifo_sel    <= '0;
            fifo_wren   <= 1'b0;
            fetch_done  <= 1'b0;
            busy        <= 1'b0;
`ifdef FETCH_TIMEOUT_EN
            wdog        <= '0;
            error       <= 1'b0;
`endif
        end else begin
            fetch_done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        base        <= base_addr;
                        row         <= '0;
                        mem_read    <= 1'b1;
                        mem_address <= base_addr;
                        busy        <= 1'b1;
                        state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                        wdog        <= '0;
                        error       <= 1'b0;
`endif
                    end
                end
                REQ: begin
                    if (!mem_waitrequest) begin
                        mem_read <= 1'b0;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    if (mem_readdatavalid) begin
                        // Element 0 goes out directly from the bus; the rest come from word.
                        word      <= mem_readdata;
                        elem      <= '0;
                        fifo_wren <= 1'b1;
                        fifo_sel  <= 4'(row);
                        fifo_data <= mem_readdata[DATA_WIDTH-1:0];
                        state     <= UNPACK;
                    end
                end
                UNPACK: begin
                    if (elem == EW'(DIM - 1)) begin
                        fifo_wren <= 1'b0;
                        fifo_sel  <= '0;
                        fifo_data <= '0;
                        if (row == RW'(DIM)) begin
                            fetch_done <= 1'b1;
                            state      <= DONE;
                        end else begin
                            row         <= row_next;
                            mem_read    <= 1'b1;
                            mem_address <= base + ADDR_WIDTH'(row_next);
                            state       <= REQ;
`ifdef FETCH_TIMEOUT_EN
                            wdog        <= '0;
`endif
                        end
                    end else begin
                        elem      <= elem + 1'b1;
                        fifo_data <= word[(int'(elem) + 1) * DATA_WIDTH +: DATA_WIDTH];
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
`ifdef FETCH_TIMEOUT_EN
            // Later assignments override the case above when the watchdog expires.
            if ((state == REQ) || (state == WAIT && !mem_readdatavalid)) begin
                if (wdog == 8'd254) begin
                    error    <= 1'b1;
                    mem_read <= 1'b0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end else begin
                    wdog <= wdog + 1'b1;
                end
            end
`endif
        end
    end

`ifndef FETCH_TIMEOUT_EN
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_data_fetcher.sv
// Self-checking bench for matrix_data_fetcher: memory responder, FIFO-write scoreboard,
// directed fetch scenarios (clean, stall, spurious inputs, mid-fetch reset, timeout).
module tb_matrix_data_fetcher;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [31:0] mem_address;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [63:0] mem_readdata;
    logic        mem_readdatavalid;
    logic [7:0]  fifo_data;
    logic [3:0]  fifo_sel;
    logic        fifo_wren;
    logic        fetch_done;
    logic        busy;
    logic        error;

    matrix_data_fetcher #(
        .DATA_WIDTH (8),
        .DIM        (8),
        .ADDR_WIDTH (32)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .start             (start),
        .base_addr         (base_addr),
        .mem_address       (mem_address),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .fifo_data         (fifo_data),
        .fifo_sel          (fifo_sel),
        .fifo_wren         (fifo_wren),
        .fetch_done        (fetch_done),
        .busy              (busy),
        .error             (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [3:0] sel;
        logic [7:0] data;
    } wr_t;

    wr_t         exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          n_wr = 0;
    int          n_acc = 0;
    int          n_done = 0;
    int          done_cyc = -1;
    int          stall_left = 0;
    logic [31:0] stall_addr = 32'h0;
    bit          stall_on = 1'b0;
    bit          spur_en = 1'b0;
    bit          no_resp = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Memory image: byte i of the word at address a is low byte of a*8+i.
    function automatic logic [63:0] mem_word(input logic [31:0] a);
        logic [63:0] w;
        for (int i = 0; i < 8; i++) w[i*8 +: 8] = 8'(a * 8 + 32'(i));
        return w;
    endfunction

    // Memory responder: one outstanding read, data valid one cycle after accept.
    initial begin
        logic        pending;
        logic [31:0] pend_addr;
        pending = 1'b0;
        pend_addr = '0;
        mem_waitrequest = 1'b0;
        mem_readdatavalid = 1'b0;
        mem_readdata = '0;
        forever begin
            @(negedge clk);
            mem_readdatavalid = 1'b0;
            mem_readdata = '0;
            mem_waitrequest = 1'b0;
            if (!rst_n) begin
                pending = 1'b0;
            end else begin
                if (pending) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = mem_word(pend_addr);
                    pending = 1'b0;
                end else if (spur_en && fifo_wren && fifo_sel == 4'd2) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata = '1;
                    spur_en = 1'b0;
                end
                if (mem_read && stall_left > 0 && (stall_on || mem_address == stall_addr)) begin
                    if (stall_on) chk("stall_addr_hold", mem_address, stall_addr);
                    stall_on = 1'b1;
                    mem_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    stall_on = 1'b0;
                end
                if (mem_read && !mem_waitrequest) begin
                    n_acc++;
                    pending = !no_resp;
                    pend_addr = mem_address;
                end
            end
        end
    end

    // FIFO-write monitor: pops the scoreboard on every write.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (fifo_wren) begin
                    wr_t e;
                    n_wr++;
                    e = (exp_q.size() > 0) ? exp_q.pop_front() : wr_t'(12'hfff);
                    chk("fifo_write", {fifo_sel, fifo_data}, {e.sel, e.data});
                end else if (fifo_sel != 4'd0 || fifo_data != 8'd0) begin
                    chk("idle_sel_data", {fifo_sel, fifo_data}, 12'h0);
                end
                if (fetch_done) begin
                    n_done++;
                    done_cyc = cyc;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic push_expected(input logic [31:0] b);
        for (int k = 0; k < 9; k++) begin
            logic [63:0] w;
            w = mem_word(b + 32'(k));
            for (int i = 0; i < 8; i++) exp_q.push_back('{sel: 4'(k), data: w[i*8 +: 8]});
        end
    endtask

    task automatic run_fetch(input logic [31:0] b, input int lat, input bit poke);
        int t0;
        n_wr = 0;
        n_acc = 0;
        n_done = 0;
        done_cyc = -1;
        push_expected(b);
        tick();
        base_addr = b;
        start = 1'b1;
        t0 = cyc;
        tick();
        start = 1'b0;
        base_addr = '0;
        for (int i = 0; i < 300 && n_done == 0; i++) begin
            tick();
            if (poke && i == 30) begin
                start = 1'b1;
                base_addr = 32'hdead;
            end else begin
                start = 1'b0;
                base_addr = '0;
            end
        end
        chk("done_latency", done_cyc - t0, lat);
        chk("busy_in_done", busy, 1'b1);
        chk("write_count", n_wr, 72);
        chk("read_count", n_acc, 9);
        chk("queue_drained", exp_q.size(), 0);
        tick();
        chk("busy_after_done", busy, 1'b0);
        repeat (3) tick();
        chk("done_pulses", n_done, 1);
        chk("error_clear", error, 1'b0);
        exp_q.delete();
    endtask

    initial begin
        bit found;
        rst_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        repeat (3) tick();
        chk("reset_outputs",
            {mem_read, mem_address, fifo_wren, fifo_data, fifo_sel, fetch_done, busy, error}, '0);
        rst_n = 1'b1;
        tick();

        run_fetch(32'h100, 91, 1'b0);

        stall_addr = 32'h104;
        stall_left = 3;
        run_fetch(32'h100, 94, 1'b0);
        chk("stall_consumed", stall_left, 0);

        spur_en = 1'b1;
        run_fetch(32'h100, 91, 1'b1);
        chk("spurious_issued", spur_en, 1'b0);

        // Reset while unpacking row 2.
        push_expected(32'h100);
        tick();
        base_addr = 32'h100;
        start = 1'b1;
        tick();
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = fifo_wren && fifo_sel == 4'd2;
        end
        chk("reached_row2", found, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort_outputs",
            {mem_read, mem_address, fifo_wren, fifo_data, fifo_sel, fetch_done, busy, error}, '0);
        exp_q.delete();
        n_wr = 0;
        repeat (2) tick();
        chk("abort_no_writes", n_wr, 0);
        rst_n = 1'b1;
        tick();
        run_fetch(32'h0, 91, 1'b0);

`ifdef FETCH_TIMEOUT_EN
        begin
            int t0;
            no_resp = 1'b1;
            n_done = 0;
            tick();
            base_addr = 32'h100;
            start = 1'b1;
            t0 = cyc;
            tick();
            start = 1'b0;
            for (int i = 0; i < 400 && cyc < t0 + 255; i++) tick();
            chk("timeout_not_yet", error, 1'b0);
            tick();
            chk("timeout_error", error, 1'b1);
            chk("timeout_busy", busy, 1'b0);
            chk("timeout_read", mem_read, 1'b0);
            repeat (5) tick();
            chk("timeout_no_done", n_done, 0);
            chk("timeout_sticky", error, 1'b1);
            no_resp = 1'b0;
            run_fetch(32'h100, 91, 1'b0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
